// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: accepts a MIPS word, decodes it, reads the register file,
// drives the ALU operand muxes/opcode, and hands the result back on a write-back handshake.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rf_rs_addr,
  output logic [REG_AW-1:0] rf_rt_addr,
  input  logic [DATA_W-1:0] rf_rs_data,
  input  logic [DATA_W-1:0] rf_rt_data,
  output logic [1:0]        alu_in1_sel,
  output logic              alu_in2_sel,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_zero,
  output logic              illegal
);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpXor = 4'b0011;
  localparam logic [3:0] OpNor = 4'b0100;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpSll = 4'b1000;
  localparam logic [3:0] OpSrl = 4'b1001;
  localparam logic [3:0] OpSra = 4'b1010;
  localparam logic [3:0] OpLui = 4'b1011;

  localparam logic [1:0] In1Rt   = 2'b00;
  localparam logic [1:0] In1ZImm = 2'b01;
  localparam logic [1:0] In1SImm = 2'b10;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDecode = 3'd1,
    StRead   = 3'd2,
    StExec   = 3'd3,
    StWb     = 3'd4
  } state_e;

  state_e r_state, w_state_next;

  logic [31:0]       r_instr;
  logic [3:0]        r_alu_op;
  logic [1:0]        r_in1_sel;
  logic              r_in2_sel;
  logic [REG_AW-1:0] r_dest;
  logic [15:0]       r_imm;
  logic [4:0]        r_shamt;
  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic [DATA_W-1:0] r_alu_in1;
  logic [DATA_W-1:0] r_alu_in2;
  logic [REG_AW-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_wb_zero;

  logic              w_legal;
  logic [3:0]        w_op;
  logic [1:0]        w_in1_sel;
  logic              w_in2_sel;
  logic [REG_AW-1:0] w_dest;
  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;

  assign w_opcode = r_instr[31:26];
  assign w_funct  = r_instr[5:0];

  // Decode works on the latched word so it is stable throughout DECODE.
  always_comb begin
    w_legal   = 1'b0;
    w_op      = OpAnd;
    w_in1_sel = In1Rt;
    w_in2_sel = 1'b0;
    w_dest    = r_instr[20:16];
    case (w_opcode)
      6'b000000: begin
        w_dest = r_instr[15:11];
        case (w_funct)
          6'b100000, 6'b100001: begin w_legal = 1'b1; w_op = OpAdd; end
          6'b100010, 6'b100011: begin w_legal = 1'b1; w_op = OpSub; end
          6'b100100:            begin w_legal = 1'b1; w_op = OpAnd; end
          6'b100101:            begin w_legal = 1'b1; w_op = OpOr;  end
          6'b100110:            begin w_legal = 1'b1; w_op = OpXor; end
          6'b100111:            begin w_legal = 1'b1; w_op = OpNor; end
          6'b101010:            begin w_legal = 1'b1; w_op = OpSlt; end
          6'b000000: begin w_legal = 1'b1; w_op = OpSll; w_in2_sel = 1'b1; end
          6'b000010: begin w_legal = 1'b1; w_op = OpSrl; w_in2_sel = 1'b1; end
          6'b000011: begin w_legal = 1'b1; w_op = OpSra; w_in2_sel = 1'b1; end
          default: w_legal = 1'b0;
        endcase
      end
      6'b001000, 6'b001001: begin w_legal = 1'b1; w_op = OpAdd; w_in1_sel = In1SImm; end
      6'b001010:            begin w_legal = 1'b1; w_op = OpSlt; w_in1_sel = In1SImm; end
      6'b001100:            begin w_legal = 1'b1; w_op = OpAnd; w_in1_sel = In1ZImm; end
      6'b001101:            begin w_legal = 1'b1; w_op = OpOr;  w_in1_sel = In1ZImm; end
      6'b001110:            begin w_legal = 1'b1; w_op = OpXor; w_in1_sel = In1ZImm; end
      6'b001111:            begin w_legal = 1'b1; w_op = OpLui; w_in1_sel = In1ZImm; end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    instr_ready  = 1'b0;
    wb_valid     = 1'b0;
    illegal      = 1'b0;
    case (r_state)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) w_state_next = StDecode;
      end
      StDecode: begin
        if (w_legal) begin
          w_state_next = StRead;
        end else begin
          illegal      = 1'b1;
          w_state_next = StIdle;
        end
      end
      StRead: w_state_next = StExec;
      StExec: w_state_next = (r_dest == '0) ? StIdle : StWb;
      StWb: begin
        wb_valid = 1'b1;
        if (wb_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Operand/ALU registers only move on the edges that leave DECODE, READ and EXEC, so they
  // hold their last values everywhere else.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr   <= '0;
      r_alu_op  <= '0;
      r_in1_sel <= '0;
      r_in2_sel <= 1'b0;
      r_dest    <= '0;
      r_imm     <= '0;
      r_shamt   <= '0;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_alu_in1 <= '0;
      r_alu_in2 <= '0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_wb_zero <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (instr_valid) r_instr <= instr;
        end
        StDecode: begin
          if (w_legal) begin
            r_alu_op  <= w_op;
            r_in1_sel <= w_in1_sel;
            r_in2_sel <= w_in2_sel;
            r_dest    <= w_dest;
            r_imm     <= r_instr[15:0];
            r_shamt   <= r_instr[10:6];
            r_rs_addr <= r_instr[25:21];
            r_rt_addr <= r_instr[20:16];
          end
        end
        StRead: begin
          case (r_in1_sel)
            In1ZImm: r_alu_in1 <= {{(DATA_W-16){1'b0}}, r_imm};
            In1SImm: r_alu_in1 <= {{(DATA_W-16){r_imm[15]}}, r_imm};
            default: r_alu_in1 <= rf_rt_data;
          endcase
          r_alu_in2 <= r_in2_sel ? {{(DATA_W-5){1'b0}}, r_shamt} : rf_rs_data;
        end
        StExec: begin
          if (r_dest != '0) begin
            r_wb_addr <= r_dest;
            r_wb_data <= alu_result;
            r_wb_zero <= alu_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign rf_rs_addr  = r_rs_addr;
  assign rf_rt_addr  = r_rt_addr;
  assign alu_in1_sel = r_in1_sel;
  assign alu_in2_sel = r_in2_sel;
  assign alu_op      = r_alu_op;
  assign alu_in1     = r_alu_in1;
  assign alu_in2     = r_alu_in2;
  assign wb_addr     = r_wb_addr;
  assign wb_data     = r_wb_data;
  assign wb_zero     = r_wb_zero;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural register file and ALU.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rf_rs_addr, rf_rt_addr;
  logic [31:0] rf_rs_data, rf_rt_data;
  logic [1:0]  alu_in1_sel;
  logic        alu_in2_sel;
  logic [3:0]  alu_op;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic        alu_zero;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_zero;
  logic        illegal;

  logic [31:0] regs [32];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rf_rs_data = regs[rf_rs_addr];
  assign rf_rt_data = regs[rf_rt_addr];

  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      4'b0000: alu_result = alu_in1 & alu_in2;
      4'b0001: alu_result = alu_in1 | alu_in2;
      4'b0010: alu_result = alu_in1 + alu_in2;
      4'b0011: alu_result = alu_in1 ^ alu_in2;
      4'b0100: alu_result = ~(alu_in1 | alu_in2);
      4'b0110: alu_result = alu_in2 - alu_in1;
      4'b0111: alu_result = {31'b0, $signed(alu_in2) < $signed(alu_in1)};
      4'b1000: alu_result = alu_in1 << alu_in2[4:0];
      4'b1001: alu_result = alu_in1 >> alu_in2[4:0];
      4'b1010: alu_result = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
      4'b1011: alu_result = alu_in1 << 16;
      default: alu_result = 32'h0;
    endcase
  end
  assign alu_zero = (alu_result == 32'h0);

  alu_issue_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .alu_in1_sel(alu_in1_sel), .alu_in2_sel(alu_in2_sel), .alu_op(alu_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_zero(wb_zero),
    .illegal(illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Offer one word; returns positioned in DECODE (one cycle after the accept edge).
  task automatic issue(input logic [31:0] word);
    instr_valid = 1'b1;
    instr       = word;
    step();
    instr_valid = 1'b0;
    instr       = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'h0;
    wb_ready    = 1'b1;
    step();
    step();
    check("rst_ready", {31'b0, instr_ready}, 32'd1);
    check("rst_wbv", {31'b0, wb_valid}, 32'd0);
    check("rst_ill", {31'b0, illegal}, 32'd0);
    check("rst_op", {28'b0, alu_op}, 32'd0);
    check("rst_in1", alu_in1, 32'd0);
    check("rst_wbdata", wb_data, 32'd0);
    reset = 1'b0;
    step();

    // sub $2,$4,$5 with $4=7, $5=9
    regs[4] = 32'd7;
    regs[5] = 32'd9;
    issue(32'h00851022);
    check("sub_dec_ready", {31'b0, instr_ready}, 32'd0);
    step();
    step();
    check("sub_op", {28'b0, alu_op}, 32'b0110);
    check("sub_sel1", {30'b0, alu_in1_sel}, 32'd0);
    check("sub_sel2", {31'b0, alu_in2_sel}, 32'd0);
    check("sub_in1", alu_in1, 32'd9);
    check("sub_in2", alu_in2, 32'd7);
    check("sub_exec_wbv", {31'b0, wb_valid}, 32'd0);
    step();
    check("sub_wbv", {31'b0, wb_valid}, 32'd1);
    check("sub_wbaddr", {27'b0, wb_addr}, 32'd2);
    check("sub_wbdata", wb_data, 32'hFFFFFFFE);
    check("sub_wbzero", {31'b0, wb_zero}, 32'd0);
    step();
    check("sub_done_ready", {31'b0, instr_ready}, 32'd1);
    check("sub_done_wbv", {31'b0, wb_valid}, 32'd0);

    // addi $3,$2,-1 with $2=1
    regs[2] = 32'd1;
    issue(32'h2043FFFF);
    step();
    step();
    check("addi_sel1", {30'b0, alu_in1_sel}, 32'b10);
    check("addi_in1", alu_in1, 32'hFFFFFFFF);
    check("addi_op", {28'b0, alu_op}, 32'b0010);
    step();
    check("addi_wbaddr", {27'b0, wb_addr}, 32'd3);
    check("addi_wbdata", wb_data, 32'h0);
    check("addi_wbzero", {31'b0, wb_zero}, 32'd1);
    step();

    // sll $2,$4,4 with $4=1
    regs[4] = 32'd1;
    issue(32'h00041100);
    step();
    step();
    check("sll_sel2", {31'b0, alu_in2_sel}, 32'd1);
    check("sll_in2", alu_in2, 32'd4);
    check("sll_op", {28'b0, alu_op}, 32'b1000);
    step();
    check("sll_wbaddr", {27'b0, wb_addr}, 32'd2);
    check("sll_wbdata", wb_data, 32'h10);
    step();

    // ori $2,$2,0xF000 with $2=1, held under back-pressure
    wb_ready = 1'b0;
    issue(32'h3442F000);
    step();
    step();
    check("ori_sel1", {30'b0, alu_in1_sel}, 32'b01);
    check("ori_in1", alu_in1, 32'h0000F000);
    check("ori_op", {28'b0, alu_op}, 32'b0001);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_wbv", {31'b0, wb_valid}, 32'd1);
      check("bp_wbdata", wb_data, 32'h0000F001);
      check("bp_ready", {31'b0, instr_ready}, 32'd0);
    end
    wb_ready = 1'b1;
    step();
    check("bp_rel_ready", {31'b0, instr_ready}, 32'd1);
    check("bp_rel_wbv", {31'b0, wb_valid}, 32'd0);

    // lw is unsupported
    issue(32'h8C000000);
    check("ill_pulse", {31'b0, illegal}, 32'd1);
    check("ill_wbv", {31'b0, wb_valid}, 32'd0);
    step();
    check("ill_clear", {31'b0, illegal}, 32'd0);
    check("ill_idle", {31'b0, instr_ready}, 32'd1);
    step();
    check("ill_nowb", {31'b0, wb_valid}, 32'd0);

    // addi $0,$1,5 retires without write-back
    regs[1] = 32'd3;
    issue(32'h20200005);
    step();
    step();
    check("r0_exec_ready", {31'b0, instr_ready}, 32'd0);
    step();
    check("r0_idle", {31'b0, instr_ready}, 32'd1);
    check("r0_nowb", {31'b0, wb_valid}, 32'd0);

    // Reset while in EXEC aborts the instruction
    regs[4] = 32'd7;
    regs[5] = 32'd9;
    issue(32'h00851022);
    step();
    step();
    check("rx_in_exec", {28'b0, alu_op}, 32'b0110);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rx_ready", {31'b0, instr_ready}, 32'd1);
    check("rx_wbv", {31'b0, wb_valid}, 32'd0);
    check("rx_op", {28'b0, alu_op}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rx_nowb", {31'b0, wb_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
